// File: rtl/result_collector.sv
// Write-back collector for the two-FU datapath: two one-entry result slots
// drained in capture order to the single memory write port.
module result_collector #(
   parameter int width = 16,
   parameter int cntw  = 8
) (
   input  logic             clk,
   input  logic             preset,
   input  logic [width-1:0] res0,
   input  logic             res0_tag,
   input  logic             res0_valid,
   output logic             res0_ready,
   input  logic [width-1:0] res1,
   input  logic             res1_tag,
   input  logic             res1_valid,
   output logic             res1_ready,
   output logic [width-1:0] wb_data,
   output logic             wb_sel,
   output logic             wb_zero,
   output logic             wb_valid,
   input  logic             wb_ready,
   output logic [cntw-1:0]  wb_count,
   output logic             tag_clash,
   output logic [2:0]       fsm_state
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      HOLD0  = 3'd1,
      HOLD1  = 3'd2,
      BOTH01 = 3'd3,
      BOTH10 = 3'd4
   } state_t;

   state_t           state, state_nx;
   logic [width-1:0] slot0_data, slot1_data;
   logic             slot0_tag, slot1_tag;
   logic             clash_q;
   logic             cap0, cap1, drn, drain1, both, tags_eq;

   // Handshakes: a transfer happens on a rising edge where valid and ready
   // are both high. Ready depends only on registered slot occupancy, and
   // wb_valid never drops or changes its payload until it is accepted.
   assign res0_ready = (state == IDLE) || (state == HOLD1);
   assign res1_ready = (state == IDLE) || (state == HOLD0);
   assign cap0       = res0_valid & res0_ready;
   assign cap1       = res1_valid & res1_ready;

   assign drain1     = (state == HOLD1) || (state == BOTH10);
   assign wb_valid   = (state != IDLE);
   assign drn        = wb_valid & wb_ready;
   assign wb_data    = drain1 ? slot1_data : slot0_data;
   assign wb_sel     = drain1 ? slot1_tag : slot0_tag;
   assign wb_zero    = (wb_data == '0);

   // The clash flag shows up in the very cycle both slots hold equal tags.
   assign both       = (state == BOTH01) || (state == BOTH10);
   assign tags_eq    = (slot0_tag == slot1_tag);
   assign tag_clash  = clash_q | (both & tags_eq);
   assign fsm_state  = state;

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: begin
            if (cap0 && cap1)  state_nx = (res0_tag <= res1_tag) ? BOTH01 : BOTH10;
            else if (cap0)     state_nx = HOLD0;
            else if (cap1)     state_nx = HOLD1;
         end
         HOLD0: begin
            if (drn && cap1)   state_nx = HOLD1;
            else if (drn)      state_nx = IDLE;
            else if (cap1)     state_nx = BOTH01;
         end
         HOLD1: begin
            if (drn && cap0)   state_nx = HOLD0;
            else if (drn)      state_nx = IDLE;
            else if (cap0)     state_nx = BOTH10;
         end
         BOTH01: if (drn) state_nx = HOLD1;
         BOTH10: if (drn) state_nx = HOLD0;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (preset) begin
         state      <= IDLE;
         slot0_data <= '0;
         slot1_data <= '0;
         slot0_tag  <= 1'b0;
         slot1_tag  <= 1'b0;
         clash_q    <= 1'b0;
         wb_count   <= '0;
      end else begin
         state <= state_nx;
         if (cap0) begin
            slot0_data <= res0;
            slot0_tag  <= res0_tag;
         end
         if (cap1) begin
            slot1_data <= res1;
            slot1_tag  <= res1_tag;
         end
         if (both && tags_eq) clash_q <= 1'b1;
         if (drn) wb_count <= wb_count + cntw'(1);
      end
   end

endmodule
